// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown_timer block.
package countdown_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_sva.sv
// Embedded protocol checker for countdown_timer; instantiated only when
// COUNTDOWN_TIMER_SVA_EN is defined.
module countdown_timer_sva
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  input logic             start,
  input logic [WIDTH-1:0] load_val,
  input state_t           state,
  input logic [WIDTH-1:0] count,
  input logic             done
);

  // Reset holds every register at its idle value.
  a_reset_vals: assert property (@(posedge clk)
    !rst_n |-> (state == IDLE && count == '0 && !done));

  a_load: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && start && load_val != '0) |=>
      (state == RUN && count == $past(load_val)));

  a_decrement: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN) |=> (count == $past(count) - WIDTH'(1)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_done_state: assert property (@(posedge clk) disable iff (!rst_n)
    done == (state == DONE));

  a_zero_load: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && start && load_val == '0) |=> (done && count == '0));

  a_no_reload: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN && start && count > WIDTH'(1)) |=> (state == RUN));

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle registered done pulse.
// Define COUNTDOWN_TIMER_SVA_EN to embed the protocol checker.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  // Named alias so hierarchical probes can read the FSM as `state`.
  state_t           state;
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = load_val;
          state_d = (load_val == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Clamp at zero so the counter can never wrap.
        if (count_q <= WIDTH'(1)) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  assign done  = done_q;
  assign count = count_q;

`ifdef COUNTDOWN_TIMER_SVA_EN
  countdown_timer_sva #(.WIDTH(WIDTH)) u_sva (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .state    (state_q),
    .count    (count_q),
    .done     (done_q)
  );
`else
  // Checker not built in this configuration.
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected per-cycle
// {count, done, state}; a monitor pops and compares after every rising edge.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] count;
    logic         done;
    state_t       st;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         done;
  logic [W-1:0] count;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int c, input bit d, input state_t s);
    exp_t e;
    e.count = W'(c);
    e.done  = d;
    e.st    = s;
    q.push_back(e);
  endtask

  // Hand-derived cycle sequence for a load of n, starting at the load edge.
  task automatic push_run(input int n);
    if (n == 0) begin
      push(0, 1'b1, DONE);
    end else begin
      for (int k = 0; k < n; k++) push(n - k, 1'b0, RUN);
      push(0, 1'b1, DONE);
    end
    push(0, 1'b0, IDLE);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Start is raised at a negedge and held for `hold` sampling edges.
  task automatic run(input int n, input int hold);
    @(negedge clk);
    start = 1'b1;
    load_val = W'(n);
    push_run(n);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    load_val = W'(4'hA);
    wait_drain();
  endtask

  // Monitor: one expected entry per rising edge while the scoreboard is non-empty.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("count", int'(count), int'(e.count));
        check("done", int'(done), int'(e.done));
        check("state", int'(dut.state), int'(e.st));
      end
    end
  end

  initial begin
    #12;
    check("rst_count", int'(count), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(5, 1);
    run(5, 4);
    run(0, 1);

    // Load 3, then pulse start during the DONE cycle: must be ignored.
    @(negedge clk);
    start = 1'b1;
    load_val = W'(3);
    push_run(3);
    push(0, 1'b0, IDLE);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_cycle", int'(done), 1);
    start = 1'b1;
    load_val = W'(9);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    run(2, 1);

    run(15, 1);

    // Reset mid-RUN must clear state without waiting for a clock edge.
    @(negedge clk);
    start = 1'b1;
    load_val = W'(10);
    push(10, 1'b0, RUN);
    push(9, 1'b0, RUN);
    push(8, 1'b0, RUN);
    push(7, 1'b0, RUN);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_drain", q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_count", int'(count), 0);
    check("midrun_rst_done", int'(done), 0);
    check("midrun_rst_state", int'(dut.state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
